// File: rtl/instruction_loader_pkg.sv
// Shared definitions for the boot-link instruction loader: sizes, checksum width
// and the load state machine encoding.
package instr_loader_pkg;

    localparam int ADDR_W    = 10;
    localparam int DATA_W    = 32;
    localparam int MAX_WORDS = 1024;
    localparam int CSUM_W    = 8;
    localparam int LEN_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CHECK,
        DONE,
        ERR
    } state_t;

    // States in which the boot link is being consumed (busy / in_ready high).
    function automatic logic is_loading(state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == DATA) || (s == CHECK);
    endfunction

endpackage

// File: rtl/instruction_loader_if.sv
// Boot-link byte stream, instruction-memory write port and load status of the loader.
interface instruction_loader_if #(
    parameter int ADDR_W = instr_loader_pkg::ADDR_W,
    parameter int DATA_W = instr_loader_pkg::DATA_W
);

    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   words_loaded;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, error, words_loaded
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, error, words_loaded
    );

endinterface

// File: rtl/byte_packer.sv
// Packs bytes MSB first into a word; word and word_valid are registered and appear
// in the cycle after the last byte of a word is accepted.
module byte_packer #(
    parameter int WORD_BYTES = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    clear,
    input  logic [7:0]              byte_in,
    input  logic                    byte_valid,
    output logic                    word_done,
    output logic [WORD_BYTES*8-1:0] word,
    output logic                    word_valid
);

    localparam int CNT_W   = $clog2(WORD_BYTES);
    localparam int SHIFT_W = (WORD_BYTES - 1) * 8;

    logic [CNT_W-1:0]   cnt_reg;
    logic [SHIFT_W-1:0] shift_reg;

    assign word_done = byte_valid && (cnt_reg == CNT_W'(WORD_BYTES - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg    <= '0;
            shift_reg  <= '0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= word_done;
            if (clear) begin
                cnt_reg <= '0;
            end else if (byte_valid) begin
                cnt_reg   <= cnt_reg + 1'b1;
                shift_reg <= {shift_reg[SHIFT_W-9:0], byte_in};
                if (word_done) begin
                    word <= {shift_reg, byte_in};
                end
            end
        end
    end

endmodule

// File: rtl/instruction_loader.sv
// Boot loader: reads a 16-bit word count, that many 4-byte words and an XOR checksum
// from the boot link, writing each word to instruction memory as it completes.
module instruction_loader #(
    parameter int ADDR_W    = instr_loader_pkg::ADDR_W,
    parameter int DATA_W    = instr_loader_pkg::DATA_W,
    parameter int MAX_WORDS = instr_loader_pkg::MAX_WORDS
) (
    input  logic                 clock,
    input  logic                 reset,
    instruction_loader_if.slave  bus
);

    import instr_loader_pkg::*;

    state_t             state_reg;
    state_t             state_next;
    logic               busy_reg;
    logic               done_reg;
    logic               error_reg;
    logic [7:0]         len_hi_reg;
    logic [LEN_W-1:0]   word_count_reg;
    logic [CSUM_W-1:0]  checksum_reg;
    logic [ADDR_W:0]    words_loaded_reg;
    logic [ADDR_W-1:0]  wr_addr_reg;

    logic               load_start;
    logic               pack_valid;
    logic               word_done;
    logic               last_word;
    logic [LEN_W-1:0]   len_word;

    assign load_start = bus.start && (state_reg == IDLE || state_reg == DONE || state_reg == ERR);
    assign pack_valid = bus.in_valid && (state_reg == DATA);
    assign len_word   = {len_hi_reg, bus.in_data};
    assign last_word  = (int'(words_loaded_reg) + 1) == int'(word_count_reg);

    byte_packer #(
        .WORD_BYTES (DATA_W / 8)
    ) u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (load_start),
        .byte_in    (bus.in_data),
        .byte_valid (pack_valid),
        .word_done  (word_done),
        .word       (bus.wr_data),
        .word_valid (bus.wr_en)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE, ERR: if (bus.start) state_next = LEN_HI;
            LEN_HI:          if (bus.in_valid) state_next = LEN_LO;
            LEN_LO: begin
                if (bus.in_valid) begin
                    state_next = (len_word == '0 || int'(len_word) > MAX_WORDS) ? ERR : DATA;
                end
            end
            DATA:            if (word_done && last_word) state_next = CHECK;
            CHECK: begin
                if (bus.in_valid) begin
                    state_next = (bus.in_data == checksum_reg) ? DONE : ERR;
                end
            end
            default:         state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            error_reg        <= 1'b0;
            len_hi_reg       <= '0;
            word_count_reg   <= '0;
            checksum_reg     <= '0;
            words_loaded_reg <= '0;
            wr_addr_reg      <= '0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= is_loading(state_next);
            if (load_start) begin
                done_reg         <= 1'b0;
                error_reg        <= 1'b0;
                words_loaded_reg <= '0;
                checksum_reg     <= '0;
            end
            if (state_next != state_reg) begin
                if (state_next == DONE) done_reg  <= 1'b1;
                if (state_next == ERR)  error_reg <= 1'b1;
            end
            if (state_reg == LEN_HI && bus.in_valid) len_hi_reg     <= bus.in_data;
            if (state_reg == LEN_LO && bus.in_valid) word_count_reg <= len_word;
            if (pack_valid) checksum_reg <= checksum_reg ^ bus.in_data;
            // Address is the pre-increment count, so a full load ends at MAX_WORDS-1.
            if (word_done) begin
                wr_addr_reg      <= words_loaded_reg[ADDR_W-1:0];
                words_loaded_reg <= words_loaded_reg + 1'b1;
            end
        end
    end

    assign bus.in_ready     = busy_reg;
    assign bus.busy         = busy_reg;
    assign bus.done         = done_reg;
    assign bus.error        = error_reg;
    assign bus.words_loaded = words_loaded_reg;
    assign bus.wr_addr      = wr_addr_reg;

endmodule
